// File: rtl/usb_sniffer_defs.sv
// Shared definitions for the USB sniffer capture path: writer FSM encoding and AXI constants.
package usb_sniffer_defs;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StAddr,
    StData,
    StResp
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/usb_capture_burst_buf.sv
// Staging register file holding one AXI burst worth of capture words.
module usb_capture_burst_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  widx_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [IdxW-1:0]  ridx_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/usb_capture_axi_writer.sv
// Drains the capture FIFO into a memory ring buffer using single-outstanding AXI4 INCR bursts
// that never cross a BURST_LEN-word boundary.
module usb_capture_axi_writer
  import usb_sniffer_defs::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_enable_i,
  input  logic        cfg_cont_i,
  input  logic        cfg_flush_i,
  input  logic [31:0] cfg_base_i,
  input  logic [31:0] cfg_end_i,
  input  logic [31:0] fifo_data_i,
  input  logic [13:0] fifo_count_i,
  output logic        fifo_rd_o,
  output logic [31:0] wr_ptr_o,
  output logic        wrapped_o,
  output logic        full_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  output logic        outport_bready_o,
  input  logic        outport_awready_i,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i
);

  localparam int unsigned IdxW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

  wr_state_e state_q, state_d;
  logic [31:0]     wr_ptr_q, wr_ptr_d;
  logic            wrapped_q, wrapped_d;
  logic            full_q, full_d;
  logic            err_q, err_d;
  logic            enable_q;
  logic [CntW-1:0] len_q, len_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic            rd_pend_q;

  logic            fifo_rd;
  logic            aw_valid, w_valid, b_ready, w_last;
  logic [IdxW-1:0] ptr_off;
  logic [CntW-1:0] room, n_sel;
  logic            count_ge_room, start;
  logic [31:0]     next_ptr;
  logic [31:0]     buf_rdata;
  logic            unused_bid;

  assign unused_bid = ^outport_bid_i;

  // Word offset of the pointer inside its BURST_LEN-aligned block.
  assign ptr_off       = (BURST_LEN > 1) ? wr_ptr_q[2 +: IdxW] : '0;
  assign room          = CntW'(BURST_LEN) - CntW'(ptr_off);
  assign count_ge_room = fifo_count_i >= 14'(room);
  assign n_sel         = count_ge_room ? room : CntW'(fifo_count_i);
  // Gated on enable_q so a burst never starts from a pointer not yet reloaded from cfg_base_i.
  assign start         = enable_q && cfg_enable_i && !full_q &&
                         (count_ge_room || (cfg_flush_i && (fifo_count_i != '0)));
  assign next_ptr      = wr_ptr_q + (32'(len_q) << 2);
  assign w_last        = beat_q == (len_q - CntOne);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    full_d    = full_q;
    err_d     = err_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    beat_d    = beat_q;
    wr_idx_d  = wr_idx_q;
    fifo_rd   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d    = n_sel;
          rd_cnt_d = '0;
          beat_d   = '0;
          wr_idx_d = '0;
          state_d  = StFill;
        end
      end
      StFill: begin
        if (rd_pend_q) begin
          wr_idx_d = wr_idx_q + IdxOne;
        end
        if (rd_cnt_q != len_q) begin
          fifo_rd  = 1'b1;
          rd_cnt_d = rd_cnt_q + CntOne;
        end else begin
          // Last word lands in the buffer at the end of this cycle.
          state_d = StAddr;
        end
      end
      StAddr: begin
        aw_valid = 1'b1;
        if (outport_awready_i) begin
          state_d = StData;
        end
      end
      StData: begin
        w_valid = 1'b1;
        if (outport_wready_i) begin
          if (w_last) begin
            state_d = StResp;
          end else begin
            beat_d = beat_q + CntOne;
          end
        end
      end
      StResp: begin
        b_ready = 1'b1;
        if (outport_bvalid_i) begin
          if (outport_bresp_i != AXI_RESP_OKAY) begin
            err_d = 1'b1;
          end
          if (next_ptr >= cfg_end_i) begin
            if (cfg_cont_i) begin
              wr_ptr_d  = cfg_base_i;
              wrapped_d = 1'b1;
            end else begin
              wr_ptr_d = next_ptr;
              full_d   = 1'b1;
            end
          end else begin
            wr_ptr_d = next_ptr;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cfg_enable_i && !enable_q) begin
      wr_ptr_d  = cfg_base_i;
      wrapped_d = 1'b0;
      full_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      enable_q  <= 1'b0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      beat_q    <= '0;
      wr_idx_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      full_q    <= full_d;
      err_q     <= err_d;
      enable_q  <= cfg_enable_i;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      beat_q    <= beat_d;
      wr_idx_q  <= wr_idx_d;
      rd_pend_q <= fifo_rd;
    end
  end

  usb_capture_burst_buf #(
    .Depth (BURST_LEN),
    .IdxW  (IdxW),
    .Width (32)
  ) u_burst_buf (
    .clk_i   (clk_i),
    .we_i    (rd_pend_q),
    .widx_i  (wr_idx_q),
    .wdata_i (fifo_data_i),
    .ridx_i  (beat_q[IdxW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign fifo_rd_o         = fifo_rd;
  assign wr_ptr_o          = wr_ptr_q;
  assign wrapped_o         = wrapped_q;
  assign full_o            = full_q;
  assign err_o             = err_q;
  assign busy_o            = state_q != StIdle;
  assign outport_awvalid_o = aw_valid;
  assign outport_awaddr_o  = aw_valid ? wr_ptr_q : '0;
  assign outport_awid_o    = aw_valid ? AXI_ID : '0;
  assign outport_awlen_o   = aw_valid ? 8'(len_q - CntOne) : '0;
  assign outport_awburst_o = aw_valid ? AXI_BURST_INCR : '0;
  assign outport_wvalid_o  = w_valid;
  assign outport_wdata_o   = w_valid ? buf_rdata : '0;
  assign outport_wstrb_o   = w_valid ? 4'hF : 4'h0;
  assign outport_wlast_o   = w_valid && w_last;
  assign outport_bready_o  = b_ready;

endmodule

// File: tb/tb_usb_capture_axi_writer.sv
// Directed bench: FIFO and AXI slave models drive the writer; checks bursts, pointer and flags.
module tb_usb_capture_axi_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, cont = 1'b0, flush = 1'b0;
  logic [31:0] base = '0, end_addr = '0;
  logic [31:0] fifo_data = '0;
  logic [13:0] fifo_count = '0;
  logic        fifo_rd;
  logic [31:0] wr_ptr;
  logic        wrapped, full, err, busy;
  logic        awvalid, wvalid, wlast, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [31:0] w_data_q [$];
  logic        w_last_q [$];
  logic        fifo_pend = 1'b0;
  logic        stall_en = 1'b0;
  int          b_count = 0;
  int          err_at = -1;
  int          proto_bad = 0;
  int          seq = 0;
  int          b0 = 0;

  always #5 clk = ~clk;

  usb_capture_axi_writer #(
    .BURST_LEN (16),
    .AXI_ID    (4'd0)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cfg_enable_i      (enable),
    .cfg_cont_i        (cont),
    .cfg_flush_i       (flush),
    .cfg_base_i        (base),
    .cfg_end_i         (end_addr),
    .fifo_data_i       (fifo_data),
    .fifo_count_i      (fifo_count),
    .fifo_rd_o         (fifo_rd),
    .wr_ptr_o          (wr_ptr),
    .wrapped_o         (wrapped),
    .full_o            (full),
    .err_o             (err),
    .busy_o            (busy),
    .outport_awvalid_o (awvalid),
    .outport_awaddr_o  (awaddr),
    .outport_awid_o    (awid),
    .outport_awlen_o   (awlen),
    .outport_awburst_o (awburst),
    .outport_wvalid_o  (wvalid),
    .outport_wdata_o   (wdata),
    .outport_wstrb_o   (wstrb),
    .outport_wlast_o   (wlast),
    .outport_bready_o  (bready),
    .outport_awready_i (awready),
    .outport_wready_i  (wready),
    .outport_bvalid_i  (bvalid),
    .outport_bresp_i   (bresp),
    .outport_bid_i     (4'h0)
  );

  // FIFO with one-cycle read latency plus an AXI write slave. Runs on the falling edge, so
  // everything it records is the handshake the DUT will see on the next rising edge.
  always @(negedge clk) begin
    if (fifo_pend && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_pend  = fifo_rd;
    fifo_count = 14'(fifo_q.size() - (fifo_pend ? 1 : 0));
    awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    bvalid  = bready && (!stall_en || ($urandom_range(0, 2) == 0));
    bresp   = (b_count == err_at) ? 2'b10 : 2'b00;
    if (awvalid && awready) begin
      aw_addr_q.push_back(awaddr);
      aw_len_q.push_back(awlen);
      if (awburst !== 2'b01 || awid !== 4'h0) proto_bad++;
    end
    if (awvalid && wvalid) proto_bad++;
    if (wvalid && wready) begin
      w_data_q.push_back(wdata);
      w_last_q.push_back(wlast);
      if (wstrb !== 4'hF) proto_bad++;
    end
    if (bvalid && bready) b_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(32'hC0DE_0000 + 32'(seq));
      exp_q.push_back(32'hC0DE_0000 + 32'(seq));
      seq++;
    end
  endtask

  task automatic wait_bursts(input int target);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if ((b_count - b0) >= target && !busy) done = 1'b1;
    end
    chk("burst_timeout", 32'(done), 32'd1);
  endtask

  task automatic restart();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    fifo_q.delete();
    exp_q.delete();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    w_last_q.delete();
    b0 = b_count;
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_data(input int n);
    chk("wbeats", 32'(w_data_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < w_data_q.size()) chk("wdata", w_data_q[i], exp_q[i]);
    end
  endtask

  initial begin
    logic seen;

    repeat (3) @(negedge clk);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_wr_ptr", wr_ptr, 32'd0);
    chk("rst_flags", {28'd0, wrapped, full, err, busy}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);

    rst = 1'b1;
    base = 32'h1000;
    end_addr = 32'h1100;
    cont = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("ptr_load", wr_ptr, 32'h1000);

    // 1: single full burst
    push_words(16);
    wait_bursts(1);
    chk("t1_aw_cnt", 32'(aw_addr_q.size()), 32'd1);
    chk("t1_awaddr", aw_addr_q[0], 32'h1000);
    chk("t1_awlen", 32'(aw_len_q[0]), 32'd15);
    check_data(16);
    for (int i = 0; i < 16; i++) chk("t1_wlast", 32'(w_last_q[i]), 32'(i == 15));
    chk("t1_wr_ptr", wr_ptr, 32'h1040);
    chk("t1_wrapped", 32'(wrapped), 32'd0);

    // 2: fill the whole ring and wrap
    restart();
    push_words(64);
    wait_bursts(4);
    chk("t2_aw_cnt", 32'(aw_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_awaddr", aw_addr_q[i], 32'h1000 + 32'(i * 'h40));
    check_data(64);
    chk("t2_wr_ptr", wr_ptr, 32'h1000);
    chk("t2_wrapped", 32'(wrapped), 32'd1);
    chk("t2_full", 32'(full), 32'd0);

    // 3: stop-when-full
    cont = 1'b0;
    restart();
    push_words(80);
    wait_bursts(4);
    repeat (60) @(negedge clk);
    chk("t3_aw_cnt", 32'(aw_addr_q.size()), 32'd4);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_wrapped", 32'(wrapped), 32'd0);
    chk("t3_wr_ptr", wr_ptr, 32'h1100);
    chk("t3_fifo_left", 32'(fifo_q.size()), 32'd16);
    chk("t3_busy", 32'(busy), 32'd0);
    check_data(64);

    // 4: flush partial bursts and boundary-limited bursts
    cont = 1'b1;
    flush = 1'b1;
    restart();
    push_words(3);
    wait_bursts(1);
    chk("t4_awlen0", 32'(aw_len_q[0]), 32'd2);
    chk("t4_ptr0", wr_ptr, 32'h100C);
    push_words(16);
    wait_bursts(3);
    chk("t4_aw_cnt", 32'(aw_addr_q.size()), 32'd3);
    chk("t4_awaddr1", aw_addr_q[1], 32'h100C);
    chk("t4_awlen1", 32'(aw_len_q[1]), 32'd12);
    chk("t4_awaddr2", aw_addr_q[2], 32'h1040);
    chk("t4_awlen2", 32'(aw_len_q[2]), 32'd2);
    chk("t4_wr_ptr", wr_ptr, 32'h104C);
    check_data(19);
    for (int i = 0; i < 19; i++) begin
      if (i < w_last_q.size()) chk("t4_wlast", 32'(w_last_q[i]), 32'(i == 2 || i == 15 || i == 18));
    end

    // 5: random stalls and an error response on the second burst
    flush = 1'b0;
    stall_en = 1'b1;
    restart();
    err_at = b_count + 1;
    push_words(48);
    wait_bursts(3);
    stall_en = 1'b0;
    err_at = -1;
    chk("t5_aw_cnt", 32'(aw_addr_q.size()), 32'd3);
    chk("t5_awaddr2", aw_addr_q[2], 32'h1080);
    check_data(48);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_wr_ptr", wr_ptr, 32'h10C0);
    chk("protocol", 32'(proto_bad), 32'd0);

    // 6: asynchronous reset in the middle of the data phase
    push_words(16);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (wvalid) seen = 1'b1;
    end
    chk("t6_reach_data", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_awvalid", 32'(awvalid), 32'd0);
    chk("t6_wvalid", 32'(wvalid), 32'd0);
    chk("t6_bready", 32'(bready), 32'd0);
    chk("t6_flags", {28'd0, wrapped, full, err, busy}, 32'd0);
    chk("t6_wr_ptr", wr_ptr, 32'd0);
    @(posedge clk);
    #1;
    chk("t6_busy_next", 32'(busy), 32'd0);
    chk("t6_wvalid_next", 32'(wvalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
